ram_bus_arbiter: RTL and testbench

Shares one 2-cycle DPI-C RAM port (en/re/we/addr/wmask/size/wdata in, registered rdata one cycle later) between NUM_MASTERS requesters, for example fetch and load/store.
- Requests use a valid/ready handshake; arbitration is round-robin.
- Exactly one transaction is in flight at a time.
- Each granted request gets one response on the granting master's response channel, held until that master accepts it.

---
 rtl/ram_bus_arb_pkg.sv | 23 ++
 rtl/ram_bus_arbiter_rr.sv | 41 ++++
 rtl/ram_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ram_bus_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bus_arb_pkg.sv
// ram_bus_arb_pkg: shared types and constants for the RAM bus arbiter.
//   state_t    : arbiter FSM state encoding
//   SIZE_*     : RAM access size codes (byte, half-word, word)
//   pick_read  : classifies an access as a read (re without we)
package ram_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // The RAM gives writes priority when both strobes are set, so a
    // request only counts as a read when we is clear.
    function automatic logic pick_read(input logic re, input logic we);
        return re & ~we;
    endfunction

endpackage

// File: rtl/ram_bus_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant selection.
//   req  [N-1:0]  : request vector
//   ptr  [IW-1:0] : highest-priority index this cycle
//   en            : grant opportunity; no grant when low
//   gnt  [N-1:0]  : one-hot grant (all zero when nothing granted)
//   idx  [IW-1:0] : index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW:0] pos;
    logic        found;

    // Walk N positions starting at ptr; pos is reduced modulo N without a
    // divider since ptr + k is always below 2N.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (en && !found && req[pos[IW-1:0]]) begin
                found               = 1'b1;
                idx                 = pos[IW-1:0];
                gnt[pos[IW-1:0]]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares one 2-cycle RAM port among NUM_MASTERS requesters.
//   clk, rst         : clock, asynchronous active-low reset
//   req_*            : per-master request channel (valid/ready), flattened
//   resp_valid/ready : per-master response handshake
//   resp_rdata       : shared response data, meaningful where resp_valid=1
//   ram_*            : RAM port; all zero when no grant is active
//   ram_rdata        : RAM read data, valid the cycle after ram_en
//
//   state | meaning
//   ------+----------------------------------------------
//   IDLE  | no transaction in flight
//   WAIT  | RAM access issued, read data arrives this cycle
//   RESP  | response held for the owning master
module ram_bus_arbiter
    import ram_bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_MASTERS-1:0]              req_valid,
    output logic [NUM_MASTERS-1:0]              req_ready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_MASTERS-1:0]              req_re,
    input  logic [NUM_MASTERS-1:0]              req_we,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] req_wmask,
    input  logic [NUM_MASTERS*2-1:0]            req_size,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_MASTERS-1:0]              resp_valid,
    input  logic [NUM_MASTERS-1:0]              resp_ready,
    output logic [DATA_WIDTH-1:0]               resp_rdata,
    output logic                                ram_en,
    output logic                                ram_re,
    output logic                                ram_we,
    output logic [ADDR_WIDTH-1:0]               ram_addr,
    output logic [DATA_WIDTH/8-1:0]             ram_wmask,
    output logic [1:0]                          ram_size,
    output logic [DATA_WIDTH-1:0]               ram_wdata,
    input  logic [DATA_WIDTH-1:0]               ram_rdata
);

    localparam int MW = DATA_WIDTH / 8;
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    state_t                  state;
    logic [IW-1:0]           rr_ptr;
    logic [IW-1:0]           owner;
    logic                    is_read;
    logic [NUM_MASTERS-1:0]  resp_valid_q;
    logic [DATA_WIDTH-1:0]   resp_buf;

    logic                    handshake;
    logic                    grant_en;
    logic                    granted;
    logic [NUM_MASTERS-1:0]  gnt;
    logic [IW-1:0]           gnt_idx;

    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [MW-1:0]           sel_wmask;
    logic [1:0]              sel_size;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    sel_re;
    logic                    sel_we;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
        return (g == IW'(NUM_MASTERS - 1)) ? '0 : g + 1'b1;
    endfunction

    assign handshake = (state == RESP) && resp_ready[owner];

    // rst gates the grant so nothing reaches the RAM while reset is held,
    // even though the state register already reads IDLE.
    assign grant_en  = rst && ((state == IDLE) || handshake);

    rr_arbiter #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_rr (
        .req (req_valid),
        .ptr (rr_ptr),
        .en  (grant_en),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign granted = |gnt;

    // Mux the granted master onto the RAM port; an empty grant leaves zeros.
    always_comb begin
        sel_addr  = '0;
        sel_wmask = '0;
        sel_size  = '0;
        sel_wdata = '0;
        sel_re    = 1'b0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gnt[i]) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wmask = req_wmask[i*MW +: MW];
                sel_size  = req_size[i*2 +: 2];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_re    = req_re[i];
                sel_we    = req_we[i];
            end
        end
    end

    assign req_ready  = gnt;
    assign ram_en     = granted;
    assign ram_re     = pick_read(sel_re, sel_we);
    assign ram_we     = sel_we;
    assign ram_addr   = sel_addr;
    assign ram_wmask  = sel_wmask;
    assign ram_size   = sel_size;
    assign ram_wdata  = sel_wdata;

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_buf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            is_read      <= 1'b0;
            resp_valid_q <= '0;
            resp_buf     <= '0;
        end else begin
            if (granted) begin
                owner   <= gnt_idx;
                is_read <= ram_re;
                rr_ptr  <= next_ptr(gnt_idx);
            end
            case (state)
                IDLE: begin
                    if (granted) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    resp_buf     <= is_read ? ram_rdata : '0;
                    resp_valid_q <= NUM_MASTERS'(1) << owner;
                    state        <= RESP;
                end
                RESP: begin
                    if (handshake) begin
                        resp_valid_q <= '0;
                        state        <= granted ? WAIT : IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= '0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb_ram_bus_arbiter: directed test of ram_bus_arbiter with two masters and
// a registered RAM model whose read data depends only on the address.
module tb_ram_bus_arbiter;
    import ram_bus_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_addr;
    logic [1:0]  req_re;
    logic [1:0]  req_we;
    logic [7:0]  req_wmask;
    logic [3:0]  req_size;
    logic [63:0] req_wdata;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_rdata;
    logic        ram_en;
    logic        ram_re;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_wmask;
    logic [1:0]  ram_size;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    ram_bus_arbiter #(
        .NUM_MASTERS (2),
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_re     (req_re),
        .req_we     (req_we),
        .req_wmask  (req_wmask),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .ram_en     (ram_en),
        .ram_re     (ram_re),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wmask  (ram_wmask),
        .ram_size   (ram_size),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd_func(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
    endfunction

    // Data is returned on every access, writes included, so a bench
    // expecting zero for writes sees through a wrongly captured read bus.
    initial ram_rdata = '0;
    always @(posedge clk) begin
        if (ram_en) ram_rdata <= rd_func(ram_addr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic [31:0] a, input logic re, input logic we,
                           input logic [3:0] mk, input logic [1:0] sz, input logic [31:0] wd);
        req_valid[m]           = 1'b1;
        req_re[m]              = re;
        req_we[m]              = we;
        req_addr[m*32 +: 32]   = a;
        req_wmask[m*4 +: 4]    = mk;
        req_size[m*2 +: 2]     = sz;
        req_wdata[m*32 +: 32]  = wd;
    endtask

    task automatic clear_req(input int m);
        req_valid[m] = 1'b0;
        req_re[m]    = 1'b0;
        req_we[m]    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        req_valid  = '0;
        req_addr   = '0;
        req_re     = '0;
        req_we     = '0;
        req_wmask  = '0;
        req_size   = '0;
        req_wdata  = '0;
        resp_ready = '0;

        // Reset with a request pending: nothing may reach the RAM.
        set_req(0, 32'h100, 1'b1, 1'b0, 4'h0, SIZE_W, 32'h0);
        step();
        step();
        check("rst_ram_en", ram_en, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_ram_addr", ram_addr, 0);

        // Single read from master0.
        rst = 1'b1;
        #1;
        check("rd_ram_en", ram_en, 1);
        check("rd_req_ready", req_ready, 2'b01);
        check("rd_ram_addr", ram_addr, 32'h100);
        check("rd_ram_re", ram_re, 1);
        check("rd_ram_we", ram_we, 0);
        step();
        clear_req(0);
        resp_ready = 2'b01;
        #1;
        check("rd_wait_resp_valid", resp_valid, 0);
        check("rd_wait_ram_en", ram_en, 0);
        step();
        check("rd_resp_valid", resp_valid, 2'b01);
        check("rd_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
        step();
        check("rd_done_resp_valid", resp_valid, 0);

        // Write from master1 (pointer now at 1).
        set_req(1, 32'h200, 1'b0, 1'b1, 4'hF, SIZE_W, 32'h1234_5678);
        resp_ready = 2'b10;
        #1;
        check("wr_req_ready", req_ready, 2'b10);
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_re", ram_re, 0);
        check("wr_ram_addr", ram_addr, 32'h200);
        check("wr_ram_wdata", ram_wdata, 32'h1234_5678);
        check("wr_ram_wmask", ram_wmask, 4'hF);
        check("wr_ram_size", ram_size, SIZE_W);
        step();
        clear_req(1);
        step();
        check("wr_resp_valid", resp_valid, 2'b10);
        check("wr_resp_rdata", resp_rdata, 0);
        step();
        check("wr_done_resp_valid", resp_valid, 0);

        // Round-robin with both masters streaming reads.
        resp_ready = 2'b11;
        set_req(0, 32'h10, 1'b1, 1'b0, 4'h0, SIZE_W, 32'h0);
        set_req(1, 32'h20, 1'b1, 1'b0, 4'h0, SIZE_W, 32'h0);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("rr_grant", req_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
            check("rr_addr", ram_addr, (i % 2 == 1) ? 32'h20 : 32'h10);
            if (i > 0) begin
                check("rr_resp_valid", resp_valid, (i % 2 == 1) ? 2'b01 : 2'b10);
                check("rr_resp_rdata", resp_rdata, rd_func((i % 2 == 1) ? 32'h10 : 32'h20));
            end
            step();
            if (i == 3) begin
                clear_req(0);
                clear_req(1);
                #1;
            end
            check("rr_wait_ram_en", ram_en, 0);
            step();
        end
        check("rr_last_resp_valid", resp_valid, 2'b10);
        check("rr_last_resp_rdata", resp_rdata, rd_func(32'h20));
        check("rr_last_ram_en", ram_en, 0);
        step();
        check("rr_done_resp_valid", resp_valid, 0);

        // Backpressure on master0 while master1 waits.
        resp_ready = 2'b00;
        set_req(0, 32'h30, 1'b1, 1'b0, 4'h0, SIZE_W, 32'h0);
        #1;
        check("bp_grant0", req_ready, 2'b01);
        step();
        clear_req(0);
        set_req(1, 32'h40, 1'b1, 1'b0, 4'h0, SIZE_W, 32'h0);
        #1;
        check("bp_wait_ram_en", ram_en, 0);
        step();
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_valid", resp_valid, 2'b01);
            check("bp_hold_rdata", resp_rdata, rd_func(32'h30));
            check("bp_hold_ram_en", ram_en, 0);
            check("bp_hold_req_ready", req_ready, 0);
            step();
        end
        resp_ready = 2'b01;
        #1;
        check("bp_accept_grant1", req_ready, 2'b10);
        check("bp_accept_addr", ram_addr, 32'h40);
        check("bp_accept_valid", resp_valid, 2'b01);
        step();
        clear_req(1);
        #1;
        check("bp_m1_wait_valid", resp_valid, 0);
        step();
        check("bp_m1_resp_valid", resp_valid, 2'b10);
        check("bp_m1_resp_rdata", resp_rdata, rd_func(32'h40));
        step();
        check("bp_m1_other_ready_ignored", resp_valid, 2'b10);
        resp_ready = 2'b10;
        step();
        check("bp_m1_done", resp_valid, 0);

        // re and we together behave as a write.
        set_req(0, 32'h300, 1'b1, 1'b1, 4'h3, SIZE_H, 32'hCAFE_F00D);
        resp_ready = 2'b01;
        #1;
        check("wp_ram_we", ram_we, 1);
        check("wp_ram_re", ram_re, 0);
        check("wp_ram_wmask", ram_wmask, 4'h3);
        check("wp_ram_size", ram_size, SIZE_H);
        check("wp_ram_wdata", ram_wdata, 32'hCAFE_F00D);
        step();
        clear_req(0);
        step();
        check("wp_resp_valid", resp_valid, 2'b01);
        check("wp_resp_rdata", resp_rdata, 0);
        step();
        check("wp_done", resp_valid, 0);

        // Pointer is at 1; a lone master0 request wraps to index 0.
        set_req(0, 32'h50, 1'b1, 1'b0, 4'h0, SIZE_W, 32'h0);
        #1;
        check("wrap_grant0", req_ready, 2'b01);
        step();
        set_req(0, 32'h60, 1'b1, 1'b0, 4'h0, SIZE_W, 32'h0);
        set_req(1, 32'h70, 1'b1, 1'b0, 4'h0, SIZE_W, 32'h0);
        #3;
        rst = 1'b0;
        #1;
        check("arst_wait_ram_en", ram_en, 0);
        check("arst_wait_req_ready", req_ready, 0);
        check("arst_wait_resp_valid", resp_valid, 0);
        step();
        check("arst_held_resp_valid", resp_valid, 0);
        check("arst_held_ram_en", ram_en, 0);
        rst = 1'b1;
        resp_ready = 2'b00;
        #1;
        check("arst_first_grant", req_ready, 2'b01);
        check("arst_first_addr", ram_addr, 32'h60);
        step();
        clear_req(0);
        clear_req(1);
        step();
        check("arst_resp_valid", resp_valid, 2'b01);
        check("arst_resp_rdata", resp_rdata, rd_func(32'h60));
        #3;
        rst = 1'b0;
        #1;
        check("arst_resp_drop_valid", resp_valid, 0);
        check("arst_resp_drop_rdata", resp_rdata, 0);
        step();
        rst = 1'b1;
        #1;
        check("arst_after_ram_en", ram_en, 0);
        check("arst_after_resp_valid", resp_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
